// File: rtl/imem_loader.sv
// Instruction memory loader: parses A5/LEN/data/CSUM byte frames into 32-bit
// word writes and holds the CPU until a checksum-verified image is in place.
module imem_loader #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam int unsigned WLW  = AW + 1;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [WLW-1:0]  len;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_sr;
  logic [7:0]      csum;
  logic [AW-1:0]   addr;
  logic [TW-1:0]   tcnt;
  logic            xfer;

  // The loader never back-pressures; only reset blocks the link.
  assign in_ready = !rst;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word_sr      <= '0;
      csum         <= '0;
      addr         <= '0;
      tcnt         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (xfer && in_data == SYNC) begin
            state    <= S_LEN;
            tcnt     <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end

        S_LEN, S_DATA, S_SUM: begin
          // An expired timeout aborts even if a byte shows up that same cycle.
          if (tcnt == TW'(TIMEOUT)) begin
            state <= S_ERR;
            error <= 1'b1;
            tcnt  <= '0;
          end else if (xfer) begin
            tcnt <= '0;
            case (state)
              S_LEN: begin
                if (in_data == 8'd0 || {24'd0, in_data} > DEPTH) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else begin
                  len          <= WLW'(in_data);
                  addr         <= '0;
                  byte_cnt     <= '0;
                  csum         <= '0;
                  words_loaded <= '0;
                  state        <= S_DATA;
                end
              end

              S_DATA: begin
                csum     <= csum ^ in_data;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                  wr_en        <= 1'b1;
                  wr_addr      <= addr;
                  wr_data      <= {word_sr, in_data};
                  addr         <= addr + AW'(1);
                  words_loaded <= words_loaded + WLW'(1);
                  if (words_loaded + WLW'(1) == len) begin
                    state <= S_SUM;
                  end
                end else begin
                  word_sr <= {word_sr[15:0], in_data};
                end
              end

              default: begin
                if (in_data == csum) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  state <= S_ERR;
                  error <= 1'b1;
                end
              end
            endcase
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model compared
// every cycle, directed frames from the test plan, then randomized frames.
module tb_imem_loader;

  localparam int DEPTH   = 64;
  localparam int AW      = 6;
  localparam int TIMEOUT = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  int n_pass = 0;
  int n_total = 0;

  task chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: tracks position within a frame by byte index only.
  bit            model_on = 1'b0;
  bit            m_in_frame = 1'b0;
  int            m_pos, m_len, m_k;
  int            m_idle;
  logic [7:0]    m_cs;
  logic [31:0]   m_word;
  logic          exp_we, exp_hold, exp_done, exp_err;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_data;
  logic [AW:0]   exp_wl;

  task model_step(input logic r, input logic v, input logic [7:0] d);
    exp_we = 1'b0;
    if (r) begin
      m_in_frame = 0; m_idle = 0;
      exp_hold = 1; exp_done = 0; exp_err = 0; exp_wl = '0;
      return;
    end
    if (!m_in_frame) begin
      if (v && d == SYNC) begin
        m_in_frame = 1; m_pos = 0; m_idle = 0;
        exp_hold = 1; exp_done = 0; exp_err = 0;
      end
      return;
    end
    if (m_idle == TIMEOUT) begin
      m_in_frame = 0; exp_err = 1;
      return;
    end
    if (!v) begin
      m_idle++;
      return;
    end
    m_idle = 0;
    m_pos++;
    if (m_pos == 1) begin
      if (d == 8'd0 || int'(d) > DEPTH) begin
        m_in_frame = 0; exp_err = 1;
      end else begin
        m_len = int'(d); m_cs = 8'h00; exp_wl = '0;
      end
    end else if (m_pos - 2 < 4 * m_len) begin
      m_k = m_pos - 2;
      m_word = {m_word[23:0], d};
      m_cs = m_cs ^ d;
      if (m_k % 4 == 3) begin
        exp_we = 1; exp_addr = AW'(m_k / 4); exp_data = m_word;
        exp_wl = (AW + 1)'(m_k / 4 + 1);
      end
    end else begin
      m_in_frame = 0;
      if (d == m_cs) begin exp_done = 1; exp_hold = 0; end
      else exp_err = 1;
    end
  endtask

  // Write log of what the DUT actually issued, used by literal checks.
  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_data[$];

  always @(negedge clk) begin
    if (model_on) begin
      chk("in_ready", in_ready, !rst);
      chk("wr_en", wr_en, exp_we);
      if (exp_we) begin
        chk("wr_addr", wr_addr, exp_addr);
        chk("wr_data", wr_data, exp_data);
      end
      chk("cpu_hold", cpu_hold, exp_hold);
      chk("done", done, exp_done);
      chk("error", error, exp_err);
      chk("words_loaded", words_loaded, exp_wl);
      if (wr_en) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
      end
    end
  end

  task step(input logic r, input logic v, input logic [7:0] d);
    rst = r; in_valid = v; in_data = d;
    @(posedge clk);
    model_step(r, v, d);
    model_on = 1'b1;
    #1;
  endtask

  task idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'($urandom));
  endtask

  logic [7:0] bq[$];

  task send_q(input bit rnd);
    int g;
    while (bq.size() > 0) begin
      if (rnd) begin
        g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18))
                                         : int'($urandom_range(0, 2));
        idle(g);
        if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 8'h00);
      end
      step(1'b0, 1'b1, bq.pop_front());
    end
  endtask

  int base;
  logic [7:0] cs, b;
  int sel, len;

  initial begin
    // Reset
    repeat (3) step(1'b1, 1'b0, 8'h00);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_hold", cpu_hold, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_error", error, 1'b0);
    chk("post_rst_wr_en", wr_en, 1'b0);

    // Good 2-word frame (checksum of the eight data bytes is C4)
    base = q_addr.size();
    bq = '{8'hA5, 8'h02, 8'h82, 8'h00, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, 8'hC4};
    send_q(0);
    idle(2);
    chk("good_nwr", q_addr.size() - base, 2);
    chk("good_a0", q_addr[base], 0);
    chk("good_d0", q_data[base], 32'h8200000A);
    chk("good_a1", q_addr[base+1], 1);
    chk("good_d1", q_data[base+1], 32'h04400800);
    chk("good_done", done, 1'b1);
    chk("good_hold", cpu_hold, 1'b0);
    chk("good_wl", words_loaded, 2);

    // Bad checksum, then resend
    base = q_addr.size();
    bq = '{8'hA5, 8'h02, 8'h82, 8'h00, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, 8'h00};
    send_q(0);
    idle(2);
    chk("badcs_nwr", q_addr.size() - base, 2);
    chk("badcs_err", error, 1'b1);
    chk("badcs_done", done, 1'b0);
    chk("badcs_hold", cpu_hold, 1'b1);
    bq = '{8'hA5, 8'h02, 8'h82, 8'h00, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, 8'hC4};
    send_q(0);
    idle(2);
    chk("resend_done", done, 1'b1);
    chk("resend_err", error, 1'b0);

    // Length bounds
    base = q_addr.size();
    bq = '{8'hA5, 8'h00};
    send_q(0);
    idle(2);
    chk("len0_err", error, 1'b1);
    chk("len0_nwr", q_addr.size() - base, 0);
    bq = '{8'hA5, 8'h41};
    send_q(0);
    idle(2);
    chk("len65_err", error, 1'b1);
    base = q_addr.size();
    cs = 8'h00;
    bq = '{8'hA5, 8'h40};
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      bq.push_back(b);
    end
    bq.push_back(cs);
    send_q(0);
    idle(2);
    chk("len64_nwr", q_addr.size() - base, 64);
    chk("len64_last_addr", q_addr[q_addr.size()-1], 63);
    chk("len64_done", done, 1'b1);
    chk("len64_wl", words_loaded, 64);

    // Timeout and garbage
    base = q_addr.size();
    bq = '{8'h11, 8'h22};
    send_q(0);
    idle(1);
    chk("garbage_done_kept", done, 1'b1);
    bq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56};
    send_q(0);
    idle(18);
    chk("tmo_err", error, 1'b1);
    chk("tmo_hold", cpu_hold, 1'b1);
    chk("tmo_nwr", q_addr.size() - base, 0);

    // Reset mid-frame
    base = q_addr.size();
    bq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_q(0);
    idle(1);
    chk("midrst_nwr", q_addr.size() - base, 1);
    chk("midrst_addr", q_addr[base], 0);
    step(1'b1, 1'b0, 8'h00);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 32'h0);
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", error, 1'b0);
    chk("midrst_wl", words_loaded, 0);
    base = q_addr.size();
    bq = '{8'hA5, 8'h02, 8'h82, 8'h00, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, 8'hC4};
    send_q(0);
    idle(2);
    chk("after_rst_nwr", q_addr.size() - base, 2);
    chk("after_rst_a0", q_addr[base], 0);
    chk("after_rst_done", done, 1'b1);

    // Randomized frames checked against the model every cycle
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        bq.push_back(b);
      end
      sel = int'($urandom_range(0, 9));
      len = (sel == 0) ? 0 : (sel == 1) ? 65 : int'($urandom_range(1, 8));
      bq.push_back(SYNC);
      bq.push_back(8'(len));
      if (len >= 1 && len <= DEPTH) begin
        cs = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
          b = 8'($urandom);
          cs = cs ^ b;
          bq.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        bq.push_back(cs);
      end
      send_q(1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
